// File: rtl/boreal_stim_scheduler.sv
// boreal_stim_scheduler
// Round-robin arbiter that shares one tVNS burst engine among N_REQ requesters.
// A pending requester is granted, a one-cycle trigger plus intensity is issued,
// the burst is tracked until the engine drops busy, and a refractory gap is
// enforced before the next dispatch.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              low blocks new dispatches (an in-flight burst completes)
//   req[N_REQ]          level requests, held until done/rej
//   req_intensity       8 bits per requester, requester i at [8i+7:8i]
//   req_done[N_REQ]     one-cycle pulse: granted burst completed
//   req_rej[N_REQ]      one-cycle pulse: zero intensity or engine ack timeout
//   engine_busy         burst-active flag from the engine
//   safety_active       engine interlock, blocks dispatch from IDLE only
//   trigger_out         one-cycle trigger to the engine
//   intensity_out       intensity to the engine, held until the next grant
//   grant_id            current or last granted requester
//   sched_busy          high whenever not IDLE
//   fault, fault_clr    sticky ack-timeout flag and its synchronous clear
module boreal_stim_scheduler #(
  parameter int unsigned N_REQ          = 3,
  parameter int unsigned REFRACT_CYCLES = 50_000_000,
  parameter int unsigned ACK_TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_intensity,
  output logic [N_REQ-1:0]     req_done,
  output logic [N_REQ-1:0]     req_rej,
  input  logic                 engine_busy,
  input  logic                 safety_active,
  output logic                 trigger_out,
  output logic [7:0]           intensity_out,
  output logic [1:0]           grant_id,
  output logic                 sched_busy,
  output logic                 fault,
  input  logic                 fault_clr
);

  localparam int unsigned IW = 8;
  localparam int unsigned TW = 32;
  localparam logic [TW-1:0] ACK_LAST     = TW'(ACK_TIMEOUT - 2);
  localparam logic [TW-1:0] REFRACT_LAST = TW'(REFRACT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_BURST,
    S_REFRACT
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      grant_q, grant_d;
  logic [IW-1:0]   inten_q, inten_d;
  logic            trig_q, trig_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] rej_q, rej_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;

  // Requests and intensities padded to four slots so 2-bit indexing is always in range.
  logic [3:0]      req_pad;
  logic [31:0]     inten_pad;
  logic [IW-1:0]   inten_a [4];
  logic [1:0]      win_c;
  logic            win_vld_c;
  logic [1:0]      cand;

  always_comb begin
    req_pad   = 4'(req);
    inten_pad = 32'(req_intensity);
    for (int i = 0; i < 4; i++) begin
      inten_a[i] = inten_pad[8*i +: 8];
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_c     = '0;
    win_vld_c = 1'b0;
    cand      = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = 2'((int'(rr_ptr_q) + k) % int'(N_REQ));
      if (!win_vld_c && req_pad[cand]) begin
        win_c     = cand;
        win_vld_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    inten_d  = inten_q;
    trig_d   = 1'b0;
    done_d   = '0;
    rej_d    = '0;
    fault_d  = fault_clr ? 1'b0 : fault_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !safety_active && win_vld_c) begin
          rr_ptr_d = win_c;
          if (inten_a[win_c] == '0) begin
            rej_d = N_REQ'(4'b0001 << win_c);
          end else begin
            grant_d = win_c;
            inten_d = inten_a[win_c];
            trig_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Compare against ACK_TIMEOUT-2 so rej lands ACK_TIMEOUT cycles after the trigger.
        if (engine_busy) begin
          state_d = S_BURST;
        end else if (timer_q == ACK_LAST) begin
          rej_d   = N_REQ'(4'b0001 << grant_q);
          fault_d = 1'b1;
          timer_d = '0;
          state_d = S_REFRACT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_BURST: begin
        if (!engine_busy) begin
          done_d  = N_REQ'(4'b0001 << grant_q);
          timer_d = '0;
          state_d = S_REFRACT;
        end
      end
      S_REFRACT: begin
        if (timer_q == REFRACT_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      rr_ptr_q <= 2'(N_REQ - 1);
      grant_q  <= '0;
      inten_q  <= '0;
      trig_q   <= 1'b0;
      done_q   <= '0;
      rej_q    <= '0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      inten_q  <= inten_d;
      trig_q   <= trig_d;
      done_q   <= done_d;
      rej_q    <= rej_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign trigger_out   = trig_q;
  assign intensity_out = inten_q;
  assign grant_id      = grant_q;
  assign req_done      = done_q;
  assign req_rej       = rej_q;
  assign sched_busy    = busy_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_boreal_stim_scheduler.sv
// Scoreboard bench for boreal_stim_scheduler: stimulus pushes expected engine
// triggers and done/rej pulses; a negedge monitor pops and compares them.
module tb_boreal_stim_scheduler;

  localparam int BURST_LEN = 50;
  localparam int K_TRIG = 0;
  localparam int K_DONE = 1;
  localparam int K_REJ  = 2;
  localparam int K_IDLE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  req;
  logic [23:0] req_intensity;
  logic [2:0]  req_done;
  logic [2:0]  req_rej;
  logic        engine_busy;
  logic        safety_active;
  logic        trigger_out;
  logic [7:0]  intensity_out;
  logic [1:0]  grant_id;
  logic        sched_busy;
  logic        fault;
  logic        fault_clr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int id;
    int inten;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  boreal_stim_scheduler #(
    .N_REQ(3),
    .REFRACT_CYCLES(20),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .req(req),
    .req_intensity(req_intensity),
    .req_done(req_done),
    .req_rej(req_rej),
    .engine_busy(engine_busy),
    .safety_active(safety_active),
    .trigger_out(trigger_out),
    .intensity_out(intensity_out),
    .grant_id(grant_id),
    .sched_busy(sched_busy),
    .fault(fault),
    .fault_clr(fault_clr)
  );

  // Engine model: busy rises the cycle after a trigger and lasts BURST_LEN cycles.
  bit       eng_dead = 1'b0;
  logic [7:0] eng_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng_cnt <= 8'd0;
    else if (trigger_out && !eng_dead) eng_cnt <= 8'(BURST_LEN);
    else if (eng_cnt != 8'd0) eng_cnt <= eng_cnt - 8'd1;
  end
  assign engine_busy = (eng_cnt != 8'd0);

  task automatic chk(input string nm, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int idx_of(input logic [2:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 3; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push(input int kind, input int id, input int inten);
    exp_t e;
    e.kind = kind; e.id = id; e.inten = inten;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input int id, input int inten);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d id %0d expected none at %0t", kind, id, $time);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_id", id, e.id);
      if (kind == K_TRIG) chk("ev_intensity", inten, e.inten);
    end
  endtask

  // Monitor: pops one expectation per observed trigger/done/rej.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trigger_out) expect_ev(K_TRIG, int'(grant_id), int'(intensity_out));
      if ((|req_done) || (|req_rej))
        chk("done_rej_exclusive", int'((|req_done) && (|req_rej)), 0);
      if (|req_done) begin
        chk("done_onehot", int'($onehot(req_done)), 1);
        chk("done_matches_grant", idx_of(req_done), int'(grant_id));
        expect_ev(K_DONE, idx_of(req_done), 0);
      end
      if (|req_rej) begin
        chk("rej_onehot", int'($onehot(req_rej)), 1);
        expect_ev(K_REJ, idx_of(req_rej), 0);
      end
    end
  end

  task automatic wait_ev(input int kind, input int maxc, input string nm, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < maxc) begin
      @(negedge clk);
      n++;
      case (kind)
        K_TRIG:  hit = trigger_out;
        K_DONE:  hit = |req_done;
        K_REJ:   hit = |req_rej;
        default: hit = !sched_busy;
      endcase
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL %s: got no event expected one within %0d cycles", nm, maxc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_trigger"}, int'(trigger_out), 0);
    chk({tag, "_intensity"}, int'(intensity_out), 0);
    chk({tag, "_grant"}, int'(grant_id), 0);
    chk({tag, "_sched_busy"}, int'(sched_busy), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_done"}, int'(req_done), 0);
    chk({tag, "_rej"}, int'(req_rej), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    enable = 1'b1;
    req = 3'b000;
    req_intensity = {8'd30, 8'd20, 8'd40};
    safety_active = 1'b0;
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_release");

    // Single requester, intensity 40, then a held request blocked by the refractory gap.
    push(K_TRIG, 0, 40); push(K_DONE, 0, 0);
    req = 3'b001;
    @(negedge clk);
    chk("t1_trig_latency", int'(trigger_out), 1);
    @(negedge clk);
    chk("t1_trig_width", int'(trigger_out), 0);
    chk("t1_sched_busy", int'(sched_busy), 1);
    chk("t1_intensity_held", int'(intensity_out), 40);
    wait_ev(K_DONE, 200, "t1_done_wait", n);
    chk("t1_done_latency", n, 51);
    chk("t1_busy_in_refract", int'(sched_busy), 1);
    push(K_TRIG, 0, 40); push(K_DONE, 0, 0);
    wait_ev(K_TRIG, 100, "t1_retrig_wait", n);
    chk("t1_refract_gap", n, 21);
    wait_ev(K_DONE, 200, "t1_done2_wait", n);
    req = 3'b000;
    wait_ev(K_IDLE, 100, "t1_idle_wait", n);

    // Fresh reset so round-robin restarts at requester 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All three requesting: grant order 0,1,2,0.
    push(K_TRIG, 0, 40); push(K_DONE, 0, 0);
    push(K_TRIG, 1, 20); push(K_DONE, 1, 0);
    push(K_TRIG, 2, 30); push(K_DONE, 2, 0);
    push(K_TRIG, 0, 40); push(K_DONE, 0, 0);
    req = 3'b111;
    for (int i = 0; i < 4; i++) wait_ev(K_DONE, 300, "t2_done_wait", n);
    req = 3'b000;
    wait_ev(K_IDLE, 100, "t2_idle_wait", n);

    // Zero-intensity requester 1 rejected, requester 2 served next.
    req_intensity = {8'd30, 8'd0, 8'd40};
    push(K_REJ, 1, 0); push(K_TRIG, 2, 30); push(K_DONE, 2, 0);
    req = 3'b110;
    @(negedge clk);
    chk("t3_rej_latency", int'(req_rej), 2);
    chk("t3_no_trigger", int'(trigger_out), 0);
    req = 3'b100;
    @(negedge clk);
    chk("t3_next_trigger", int'(trigger_out), 1);
    chk("t3_next_grant", int'(grant_id), 2);
    wait_ev(K_DONE, 200, "t3_done_wait", n);
    req = 3'b000;
    req_intensity = {8'd30, 8'd20, 8'd40};
    wait_ev(K_IDLE, 100, "t3_idle_wait", n);

    // Dead engine: timeout rej and sticky fault, then clear.
    eng_dead = 1'b1;
    push(K_TRIG, 0, 40); push(K_REJ, 0, 0);
    req = 3'b001;
    wait_ev(K_TRIG, 5, "t4_trig_wait", n);
    chk("t4_trig_latency", n, 1);
    wait_ev(K_REJ, 20, "t4_rej_wait", n);
    chk("t4_timeout_latency", n, 8);
    chk("t4_fault_set", int'(fault), 1);
    req = 3'b000;
    @(negedge clk);
    chk("t4_fault_sticky", int'(fault), 1);
    wait_ev(K_IDLE, 100, "t4_idle_wait", n);
    fault_clr = 1'b1;
    @(negedge clk);
    chk("t4_fault_clr", int'(fault), 0);
    // Clear held through a second timeout: set must win on the timeout cycle.
    push(K_TRIG, 0, 40); push(K_REJ, 0, 0);
    req = 3'b001;
    wait_ev(K_TRIG, 5, "t4b_trig_wait", n);
    wait_ev(K_REJ, 20, "t4b_rej_wait", n);
    chk("t4_set_wins", int'(fault), 1);
    req = 3'b000;
    @(negedge clk);
    chk("t4_clr_after_set", int'(fault), 0);
    fault_clr = 1'b0;
    eng_dead = 1'b0;
    wait_ev(K_IDLE, 100, "t4b_idle_wait", n);

    // safety_active blocks dispatch; release dispatches next cycle.
    safety_active = 1'b1;
    req = 3'b010;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (trigger_out) n++;
    end
    chk("t5_safety_block", n, 0);
    chk("t5_safety_idle", int'(sched_busy), 0);
    push(K_TRIG, 1, 20); push(K_DONE, 1, 0);
    safety_active = 1'b0;
    @(negedge clk);
    chk("t5_safety_release", int'(trigger_out), 1);
    wait_ev(K_DONE, 200, "t5_done_wait", n);
    req = 3'b000;
    wait_ev(K_IDLE, 100, "t5_idle_wait", n);

    // enable low blocks dispatch; raising it dispatches next cycle.
    enable = 1'b0;
    req = 3'b010;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (trigger_out) n++;
    end
    chk("t5_enable_block", n, 0);
    push(K_TRIG, 1, 20); push(K_DONE, 1, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_enable_release", int'(trigger_out), 1);
    wait_ev(K_DONE, 200, "t5b_done_wait", n);
    req = 3'b000;
    wait_ev(K_IDLE, 100, "t5b_idle_wait", n);

    // Reset mid-burst on requester 2, then requester 0 wins first.
    push(K_TRIG, 2, 30);
    req = 3'b100;
    wait_ev(K_TRIG, 5, "t6_trig_wait", n);
    repeat (10) @(negedge clk);
    chk("t6_in_burst", int'(sched_busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    req = 3'b000;
    repeat (2) @(negedge clk);
    chk("t6_no_pending", exp_q.size(), 0);
    rst_n = 1'b1;
    push(K_TRIG, 0, 40); push(K_DONE, 0, 0);
    req = 3'b111;
    wait_ev(K_TRIG, 5, "t6_retrig_wait", n);
    chk("t6_trig_latency", n, 1);
    chk("t6_first_grant", int'(grant_id), 0);
    wait_ev(K_DONE, 200, "t6_done_wait", n);
    req = 3'b000;
    wait_ev(K_IDLE, 100, "t6_idle_wait", n);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
